// File: rtl/keystream_uart_feeder_pkg.sv
// Shared types and constants for the keystream-to-UART feeder.
package keystream_uart_feeder_pkg;

    localparam int unsigned BLOCK_W_DEF   = 512;
    localparam int unsigned NUM_BYTES_DEF = BLOCK_W_DEF / 8;
    localparam int unsigned INDEX_W       = 64;
    localparam int unsigned TMO_W         = 16;
    localparam int unsigned SETTLE_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_CORE,
        LOAD,
        SEND,
        WAIT_START,
        WAIT_DONE,
        NEXT
    } state_t;

endpackage

// File: rtl/keystream_uart_feeder_bit_sync.sv
// Multi-flop synchronizer; resets high because the UART idle level is 1.
module keystream_uart_feeder_bit_sync
    import keystream_uart_feeder_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/keystream_uart_feeder.sv
// Requests keystream blocks from the cipher core and streams them byte-wise
// (LSB first) into a UART transmitter, advancing the block counter per block.
module keystream_uart_feeder
    import keystream_uart_feeder_pkg::*;
#(
    parameter int unsigned BLOCK_W       = BLOCK_W_DEF,
    parameter int unsigned NUM_BYTES     = BLOCK_W / 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned START_TIMEOUT = 4096,
    parameter int unsigned CORE_SETTLE   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               core_start,
    output logic [INDEX_W-1:0] core_index,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_out,
    output logic [7:0]         tx_byte,
    output logic               tx_en,
    output logic               tx_send,
    input  logic               tx_done,
    output logic               busy,
    output logic               err
);

    localparam int unsigned BIDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [BIDX_W-1:0]   LAST_BYTE   = BIDX_W'(NUM_BYTES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(START_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(CORE_SETTLE);

    state_t               state_q, state_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic [BIDX_W-1:0]    k_q, k_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [INDEX_W-1:0]   index_d;
    logic [7:0]           byte_d;
    logic                 send_d;
    logic                 err_d;
    logic                 start_d;
    logic                 busy_d;
    logic                 done_s;
    logic [BIDX_W+2:0]    bit_base;

    keystream_uart_feeder_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_done_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_done),
        .q     (done_s)
    );

    assign bit_base = {k_q, 3'b000};

    // State and datapath registers; every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            block_q    <= '0;
            k_q        <= '0;
            settle_q   <= '0;
            tmo_q      <= '0;
            core_index <= '0;
            tx_byte    <= '0;
            tx_en      <= 1'b0;
            tx_send    <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            block_q    <= block_d;
            k_q        <= k_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            core_index <= index_d;
            tx_byte    <= byte_d;
            tx_en      <= send_d;
            tx_send    <= send_d;
            err        <= err_d;
            core_start <= start_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-register logic for the block/byte handshake.
    always_comb begin
        state_d  = state_q;
        block_d  = block_q;
        k_d      = k_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        index_d  = core_index;
        byte_d   = tx_byte;
        send_d   = tx_send;
        err_d    = err;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = START;
                end
            end
            START: begin
                settle_d = SETTLE_INIT;
                state_d  = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else if (core_done) begin
                    block_d = core_out;
                    k_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byte_d = block_q[bit_base +: 8];
                if (done_s) begin
                    send_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!done_s) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    send_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done_s) begin
                    send_d  = 1'b0;
                    state_d = NEXT;
                    // Counter is visible in NEXT, a cycle ahead of the next start.
                    if (k_q == LAST_BYTE) begin
                        index_d = core_index + 1'b1;
                    end
                end
            end
            NEXT: begin
                if (k_q != LAST_BYTE) begin
                    k_d     = k_q + 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = run ? START : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == START);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: doc/keystream_uart_feeder.md
# keystream_uart_feeder

Downstream of the `chacha20` core and upstream of `uart_tx_8n1`. The block requests 512-bit keystream blocks from the core and latches each one. It then serializes the block into 64 bytes, least-significant byte first, and drives the UART transmitter's send/enable/done handshake once per byte. After the last byte of a block it advances the block counter (`core_index`), so the link streams a continuous keystream instead of a single byte.

## Interface
- `BLOCK_W`, 512: keystream block width in bits; must be a multiple of 8.
- `NUM_BYTES`, `BLOCK_W/8`: bytes per block.
- `SYNC_STAGES`, 2: synchronizer depth for `tx_done`.
- `START_TIMEOUT`, 4096: `clk` cycles allowed for `tx_done` to fall after send.
- `CORE_SETTLE`, 2: cycles after `core_start` during which `core_done` is ignored.

Ports:
- `clk`  in  1  system clock (12 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; stream while high.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_index`  out  64  block counter to the core.
- `core_done`  in  1  core level, high when `core_out` is valid.
- `core_out`  in  `BLOCK_W`  keystream block.
- `tx_byte`  out  8  byte to the UART.
- `tx_en`, `tx_send`  out  1  UART enable/send, asserted together.
- `tx_done`  in  1  UART idle flag from the baud-clock domain; asynchronous to `clk`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky start-timeout flag; cleared only by reset.

## Operation
- Reset values: `core_start`=0, `core_index`=0, `tx_byte`=0, `tx_en`=`tx_send`=0, `busy`=0, `err`=0, state IDLE, byte index 0.
- `tx_done` passes through a `SYNC_STAGES` flop chain. All handshake decisions use the synchronized value `done_s`.

State machine:
- IDLE: when `run`=1, go to START.
- START: `core_start`=1 for this cycle only; load the settle counter; go to WAIT_CORE.
- WAIT_CORE: ignore `core_done` for `CORE_SETTLE` cycles. After that, `core_done`=1 latches `core_out` into the block register, sets byte index to 0, and goes to LOAD.
- LOAD: `tx_byte` = block[8k+7:8k]. When `done_s`=1, go to SEND.
- SEND: set `tx_en`=`tx_send`=1; clear the timeout counter; go to WAIT_START.
- WAIT_START: when `done_s`=0, go to WAIT_DONE. If the counter reaches `START_TIMEOUT`:
  - set `err`;
  - drop `tx_en`/`tx_send`;
  - return to LOAD and retry the same byte.
- WAIT_DONE: when `done_s`=1, drop `tx_en`/`tx_send` and go to NEXT.
- NEXT, if k<`NUM_BYTES`-1: increment k and go to LOAD.
- NEXT, if k=`NUM_BYTES`-1: increment `core_index` (wraps 2^64-1 → 0). Then go to START if `run`=1, otherwise IDLE.

Boundary conditions:
- `run` falling mid-block: the current block completes, then the block returns to IDLE. No byte is ever truncated.
- `run` rising while `busy`=1: no effect.
- Reset mid-byte: all outputs return to their reset values immediately (asynchronous). The UART may still finish its current frame; the block waits for `done_s`=1 in LOAD before sending anything new.
- A `core_done` glitch or a change on `core_out` after latching has no effect: the latched block is used.

## Timing
- START → `core_start` high for exactly 1 cycle.
- Block latch occurs on the first cycle where `core_done`=1, provided at least `CORE_SETTLE` cycles have passed since `core_start`.
- `tx_byte` is stable from LOAD until `tx_send` falls.
- `tx_send` stays high for at least (synchronizer latency + 1) cycles. It falls exactly one cycle after `done_s` rises in WAIT_DONE.
- `done_s` lags `tx_done` by `SYNC_STAGES` cycles.
- Per-byte overhead beyond the UART frame: at most `SYNC_STAGES`+4 cycles.
- `core_index` updates in the NEXT cycle of the last byte, one cycle before the next `core_start`.

## Structure
- Shared package holds:
  - state enum (IDLE, START, WAIT_CORE, LOAD, SEND, WAIT_START, WAIT_DONE, NEXT);
  - `BLOCK_W` and `NUM_BYTES` defaults;
  - counter width constants.
- One sub-module: `bit_sync` (`SYNC_STAGES`-deep flop chain, reset to 1 = UART idle).
- Byte select is an indexed part-select on the latched block register, not a shifter.

## Test plan
- Reset, then `run`=1 with a core model returning `core_out`=512'h…0302_0100 (byte k = k) → the UART model receives bytes 0x00, 0x01, … 0x3F in order; `core_index` becomes 1.
- `run` held high for 3 blocks → exactly 3 `core_start` pulses; `core_index` = 0, 1, 2 presented; 192 bytes received with no gaps or duplicates.
- `run` dropped at byte 10 → the remaining 54 bytes are still sent, then IDLE, `busy`=0, and no further `core_start`.
- UART model never lowers `tx_done` → after 4096 cycles `err`=1 and `tx_send` drops. When the model recovers, the same byte value is resent.
- `rst_n` asserted in WAIT_DONE → outputs are 0 in the same cycle and `core_index`=0. After release with `run`=1, a fresh block starts from byte 0.
- `core_index` preset to 2^64-1 via a forced start → after the block it wraps to 0.
